cache_ctrl_wb: RTL and testbench
================================

Name: cache_ctrl_wb

Overview:
- Parametrised successor to the lab cache controller FSM.
- Direct-mapped, write-back, write-allocate controller with multi-word line refill and dirty-line eviction.
- Memory latency and line length are parameters; there is no hard-coded wait load value.
- Sits between the CPU request port and the tag/data arrays plus the main-memory model; drives array write enables, mux selects and memory strobes.

Parameters:
- MEM_LAT, 4, memory cycles per beat after strobe; legal range 1..255.
- LINE_WORDS, 4, words per cache line; power of 2, minimum 1.
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cpu_strobe  in  1  CPU request; sampled only in IDLE
- cpu_rw  in  1  1 = write, 0 = read; CPU holds it stable until cpu_ready
- hit  in  1  tag match AND valid, from the arrays
- dirty  in  1  dirty bit of the indexed line
- cpu_ready  out  1  one-cycle completion pulse
- data_we  out  1  data array write enable
- fill_sel  out  1  data array write source: 1 = memory, 0 = CPU
- tag_we  out  1  tag array write
- valid_set  out  1  set valid bit
- dirty_set  out  1  set dirty bit
- dirty_clr  out  1  clear dirty bit
- mem_strobe  out  1  one-cycle memory request
- mem_rw  out  1  1 = write to memory, 0 = read
- wb_tag_sel  out  1  1 = memory address uses the stored (victim) tag
- word_idx  out  max(1,$clog2(LINE_WORDS))  current beat index

Behaviour:
- Reset: state IDLE, all outputs 0, word_idx 0, wait counter 0. Reset mid-transaction aborts immediately; no further strobes or writes are issued.
- Outputs are decoded combinationally from the state plus hit/dirty/cpu_rw and the counter's zero flag.
- Any output not listed for a state is 0.
- IDLE:
  - cpu_strobe = 1 -> LOOKUP.
  - Otherwise stay in IDLE.
- LOOKUP:
  - Read hit: cpu_ready = 1 -> IDLE.
  - Write hit: data_we = 1, fill_sel = 0, dirty_set = 1, cpu_ready = 1 -> IDLE.
  - Miss with dirty = 1: -> WB_REQ, word_idx = 0.
  - Miss with dirty = 0: -> FILL_REQ, word_idx = 0.
- WB_REQ:
  - mem_strobe = 1, mem_rw = 1, wb_tag_sel = 1.
  - Load counter with MEM_LAT-1 -> WB_WAIT.
- WB_WAIT:
  - mem_rw = 1, wb_tag_sel = 1.
  - Counter decrements each cycle.
  - Counter at 0, not last beat: word_idx++ -> WB_REQ.
  - Counter at 0, last beat: word_idx = 0 -> FILL_REQ.
- FILL_REQ:
  - mem_strobe = 1, mem_rw = 0.
  - Load counter with MEM_LAT-1 -> FILL_WAIT.
- FILL_WAIT:
  - Counter decrements each cycle.
  - Counter at 0: data_we = 1, fill_sel = 1.
  - Counter at 0, not last beat: word_idx++ -> FILL_REQ.
  - Counter at 0, last beat: additionally tag_we = 1, valid_set = 1, dirty_clr = 1; word_idx wraps to 0 -> LOOKUP (replay).
- Replay: the replayed LOOKUP always hits. A replayed write completes as a write hit and sets dirty.
- Latency (strobe seen in IDLE at cycle 0):
  - Hit: cpu_ready at cycle 1.
  - Each beat costs 1 + MEM_LAT cycles.
  - Clean miss: ready at 2 + LINE_WORDS*(1+MEM_LAT).
  - Dirty miss: ready at 2 + 2*LINE_WORDS*(1+MEM_LAT).
- cpu_strobe outside IDLE is ignored; there is no queueing.
- Back-to-back requests: strobe high in the cycle after cpu_ready is accepted. Minimum request spacing is 2 cycles.
- MEM_LAT = 1: the WAIT states last exactly one cycle with the counter at 0.
- LINE_WORDS = 1: word_idx is held at 0 and every beat is the last beat.

Optional Feature:
- Macro CACHE_CTRL_PERF_CNT_EN.
- When defined:
  - Adds outputs hit_cnt[CNT_W] and miss_cnt[CNT_W].
  - A LOOKUP that is not a replay increments hit_cnt on a hit and miss_cnt on a miss.
  - Replay lookups are not counted; a 1-bit replay flag distinguishes them.
  - Both counters saturate at all-ones.
  - Both counters clear on reset.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package cache_ctrl_pkg:
  - State enum: IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT.
  - Constants MEM_RD = 0, MEM_WR = 1, SRC_CPU = 0, SRC_MEM = 1.
- One sub-module cache_wait_ctr:
  - Inputs: load, load value, clk, reset.
  - Output: zero flag.
  - Parametrised width; counts down to 0 and holds there.
  - Replaces the fixed-load wait counter.

Test Plan:
- Read hit (hit = 1, MEM_LAT = 4, LINE_WORDS = 4) -> cpu_ready at cycle 1; no mem_strobe; data_we = 0.
- Write hit -> cycle 1: data_we = 1, fill_sel = 0, dirty_set = 1, cpu_ready = 1.
- Clean read miss (hit = 0, dirty = 0):
  - 4 mem_strobe pulses with mem_rw = 0, at cycles 2, 7, 12, 17; word_idx 0..3.
  - data_we with fill_sel = 1 at cycles 6, 11, 16, 21.
  - Cycle 21: tag_we = 1, valid_set = 1, dirty_clr = 1.
  - Bench raises hit; cpu_ready at cycle 22.
- Dirty write miss:
  - 4 writeback strobes (mem_rw = 1, wb_tag_sel = 1), then 4 fill strobes.
  - cpu_ready at cycle 42 with dirty_set = 1 and data_we = 1, fill_sel = 0.
- Reset asserted during FILL_WAIT beat 2 -> next cycle: IDLE, all outputs 0, word_idx 0; a new strobe then completes normally.
- MEM_LAT = 1, LINE_WORDS = 1, clean miss -> ready at cycle 4.
- With CACHE_CTRL_PERF_CNT_EN: hit_cnt = 1, miss_cnt = 1; replay not counted; CNT_W = 2 saturates at 3.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared state encoding and mux/strobe constants for the write-back cache controller.
package cache_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WB_REQ,
      WB_WAIT,
      FILL_REQ,
      FILL_WAIT
   } state_t;

   localparam logic MEM_RD  = 1'b0;
   localparam logic MEM_WR  = 1'b1;
   localparam logic SRC_CPU = 1'b0;
   localparam logic SRC_MEM = 1'b1;

endpackage

// File: rtl/cache_wait_ctr.sv
// Memory-latency down-counter: load sets the count, it then decrements to 0 and holds.
module cache_wait_ctr #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/cache_ctrl_wb.sv
// Direct-mapped write-back/write-allocate cache controller with multi-beat evict and refill.
// Define CACHE_CTRL_PERF_CNT_EN to add saturating hit/miss counters (replay lookups excluded).
module cache_ctrl_wb
   import cache_ctrl_pkg::*;
#(
   parameter int MEM_LAT    = 4,
   parameter int LINE_WORDS = 4,
   parameter int CNT_W      = 16,
   localparam int IW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_strobe,
   input  logic          cpu_rw,
   input  logic          hit,
   input  logic          dirty,
   output logic          cpu_ready,
   output logic          data_we,
   output logic          fill_sel,
   output logic          tag_we,
   output logic          valid_set,
   output logic          dirty_set,
   output logic          dirty_clr,
   output logic          mem_strobe,
   output logic          mem_rw,
   output logic          wb_tag_sel,
   output logic [IW-1:0] word_idx
`ifdef CACHE_CTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
`endif
);

   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LAT - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(LINE_WORDS - 1);

   state_t        state, next;
   logic [IW-1:0] idx_nxt;
   logic          ctr_load, ctr_zero, last_beat;

   assign last_beat = (word_idx == LAST_IDX);

   cache_wait_ctr #(.W(CW)) u_wait (
      .clk      (clk),
      .reset    (reset),
      .load     (ctr_load),
      .load_val (LOAD_VAL),
      .zero     (ctr_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         word_idx <= '0;
      end else begin
         state    <= next;
         word_idx <= idx_nxt;
      end
   end

   always_comb begin
      next       = state;
      idx_nxt    = word_idx;
      ctr_load   = 1'b0;
      cpu_ready  = 1'b0;
      data_we    = 1'b0;
      fill_sel   = SRC_CPU;
      tag_we     = 1'b0;
      valid_set  = 1'b0;
      dirty_set  = 1'b0;
      dirty_clr  = 1'b0;
      mem_strobe = 1'b0;
      mem_rw     = MEM_RD;
      wb_tag_sel = 1'b0;
      case (state)
         IDLE: if (cpu_strobe) next = LOOKUP;
         LOOKUP: begin
            if (hit) begin
               cpu_ready = 1'b1;
               if (cpu_rw == MEM_WR) begin
                  data_we   = 1'b1;
                  fill_sel  = SRC_CPU;
                  dirty_set = 1'b1;
               end
               next = IDLE;
            end else begin
               idx_nxt = '0;
               next    = dirty ? WB_REQ : FILL_REQ;
            end
         end
         WB_REQ: begin
            mem_strobe = 1'b1;
            mem_rw     = MEM_WR;
            wb_tag_sel = 1'b1;
            ctr_load   = 1'b1;
            next       = WB_WAIT;
         end
         WB_WAIT: begin
            mem_rw     = MEM_WR;
            wb_tag_sel = 1'b1;
            if (ctr_zero) begin
               idx_nxt = last_beat ? '0 : word_idx + 1'b1;
               next    = last_beat ? FILL_REQ : WB_REQ;
            end
         end
         FILL_REQ: begin
            mem_strobe = 1'b1;
            mem_rw     = MEM_RD;
            ctr_load   = 1'b1;
            next       = FILL_WAIT;
         end
         FILL_WAIT: begin
            if (ctr_zero) begin
               data_we  = 1'b1;
               fill_sel = SRC_MEM;
               if (last_beat) begin
                  // Line is complete: install the tag and replay the original request.
                  tag_we    = 1'b1;
                  valid_set = 1'b1;
                  dirty_clr = 1'b1;
                  idx_nxt   = '0;
                  next      = LOOKUP;
               end else begin
                  idx_nxt = word_idx + 1'b1;
                  next    = FILL_REQ;
               end
            end
         end
         default: next = IDLE;
      endcase
   end

`ifdef CACHE_CTRL_PERF_CNT_EN
   logic replay;

   always_ff @(posedge clk) begin
      if (reset) begin
         replay   <= 1'b0;
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (state == FILL_WAIT && next == LOOKUP)
            replay <= 1'b1;
         else if (state == LOOKUP)
            replay <= 1'b0;
         if (state == LOOKUP && !replay) begin
            if (hit && hit_cnt != '1)
               hit_cnt <= hit_cnt + 1'b1;
            if (!hit && miss_cnt != '1)
               miss_cnt <= miss_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Bench for cache_ctrl_wb: two instances (4/4 and 1/1 geometry) checked cycle by cycle against a schedule model.
module tb_cache_ctrl_wb;

   logic clk = 1'b0;
   logic reset, rw, hit, dirty, strobe_a, strobe_b;
   always #5 clk = ~clk;

   logic       rdy_a, dwe_a, fsel_a, twe_a, vset_a, dset_a, dclr_a, mstb_a, mrw_a, wbt_a;
   logic       rdy_b, dwe_b, fsel_b, twe_b, vset_b, dset_b, dclr_b, mstb_b, mrw_b, wbt_b;
   logic [1:0] idx_a;
   logic [0:0] idx_b;
`ifdef CACHE_CTRL_PERF_CNT_EN
   logic [15:0] hc_a, mc_a;
   logic [1:0]  hc_b, mc_b;
`endif

   cache_ctrl_wb u_a (
      .clk(clk), .reset(reset), .cpu_strobe(strobe_a), .cpu_rw(rw), .hit(hit), .dirty(dirty),
      .cpu_ready(rdy_a), .data_we(dwe_a), .fill_sel(fsel_a), .tag_we(twe_a), .valid_set(vset_a),
      .dirty_set(dset_a), .dirty_clr(dclr_a), .mem_strobe(mstb_a), .mem_rw(mrw_a),
      .wb_tag_sel(wbt_a), .word_idx(idx_a)
`ifdef CACHE_CTRL_PERF_CNT_EN
      , .hit_cnt(hc_a), .miss_cnt(mc_a)
`endif
   );

   cache_ctrl_wb #(.MEM_LAT(1), .LINE_WORDS(1), .CNT_W(2)) u_b (
      .clk(clk), .reset(reset), .cpu_strobe(strobe_b), .cpu_rw(rw), .hit(hit), .dirty(dirty),
      .cpu_ready(rdy_b), .data_we(dwe_b), .fill_sel(fsel_b), .tag_we(twe_b), .valid_set(vset_b),
      .dirty_set(dset_b), .dirty_clr(dclr_b), .mem_strobe(mstb_b), .mem_rw(mrw_b),
      .wb_tag_sel(wbt_b), .word_idx(idx_b)
`ifdef CACHE_CTRL_PERF_CNT_EN
      , .hit_cnt(hc_b), .miss_cnt(mc_b)
`endif
   );

   // {word_idx[7:0], ready, data_we, fill_sel, tag_we, valid_set, dirty_set, dirty_clr, mem_strobe, mem_rw, wb_tag_sel}
   logic [17:0] obs_a, obs_b;
   assign obs_a = {6'b0, idx_a, rdy_a, dwe_a, fsel_a, twe_a, vset_a, dset_a, dclr_a, mstb_a, mrw_a, wbt_a};
   assign obs_b = {7'b0, idx_b, rdy_b, dwe_b, fsel_b, twe_b, vset_b, dset_b, dclr_b, mstb_b, mrw_b, wbt_b};

   int n_cmp = 0;
   int n_fail = 0;
   int mh_a = 0, mm_a = 0, mh_b = 0, mm_b = 0;

   function automatic int ready_cycle(input int m, input int l, input bit h, input bit d);
      return h ? 1 : 2 + ((d ? 2 : 1) * l * (1 + m));
   endfunction

   // Expected outputs k cycles after the strobe is accepted in IDLE.
   function automatic logic [17:0] model(input int k, input int m, input int l,
                                         input bit w, input bit h, input bit d);
      logic [9:0] f;
      int idx, p, nb, r, j, beat, off;
      f = '0; idx = 0; p = 1 + m; nb = d ? l : 0;
      r = ready_cycle(m, l, h, d);
      if (k == r) begin
         f[9] = 1'b1;
         if (w) begin f[8] = 1'b1; f[4] = 1'b1; end
      end else if (!h && k >= 2 && k < r) begin
         j = k - 2; beat = j / p; off = j % p;
         f[2] = (off == 0);
         if (beat < nb) begin
            idx = beat; f[1] = 1'b1; f[0] = 1'b1;
         end else begin
            idx = beat - nb;
            if (off == p - 1) begin
               f[8] = 1'b1; f[7] = 1'b1;
               if (idx == l - 1) begin f[6] = 1'b1; f[5] = 1'b1; f[3] = 1'b1; end
            end
         end
      end
      return {8'(idx), f};
   endfunction

   task automatic idle_check(input int n, input string name);
      strobe_a = 1'b0; strobe_b = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         n_cmp++;
         if (obs_a !== 18'h0 || obs_b !== 18'h0) begin
            n_fail++;
            $display("FAIL %s: got a=%h b=%h exp 0", name, obs_a, obs_b);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic run_txn(input int sel, input bit w, input bit h, input bit d,
                          input bit junk, input int exp_ready, input string name);
      int m, l, r, got_ready;
      logic [17:0] ob, ex;
      m = sel ? 1 : 4; l = sel ? 1 : 4;
      r = ready_cycle(m, l, h, d);
      got_ready = -1;
      rw = w; dirty = d;
      for (int k = 0; k <= r; k++) begin
         hit = (k == 1) ? h : (k == r);
         if (sel == 0) begin
            strobe_a = (k == 0) ? 1'b1 : (junk ? 1'($urandom_range(0, 1)) : 1'b0);
            strobe_b = 1'b0;
         end else begin
            strobe_b = (k == 0) ? 1'b1 : (junk ? 1'($urandom_range(0, 1)) : 1'b0);
            strobe_a = 1'b0;
         end
         @(negedge clk);
         ob = sel ? obs_b : obs_a;
         ex = model(k, m, l, w, h, d);
         n_cmp++;
         if (ob !== ex) begin
            n_fail++;
            $display("FAIL %s cyc %0d: got %h exp %h", name, k, ob, ex);
         end
         if (ob[9] === 1'b1 && got_ready < 0) got_ready = k;
         @(posedge clk); #1;
      end
      strobe_a = 1'b0; strobe_b = 1'b0; hit = 1'b0;
      if (exp_ready >= 0) begin
         n_cmp++;
         if (got_ready != exp_ready) begin
            n_fail++;
            $display("FAIL %s ready cycle: got %0d exp %0d", name, got_ready, exp_ready);
         end
      end
`ifdef CACHE_CTRL_PERF_CNT_EN
      if (sel == 0) begin
         if (h) mh_a = (mh_a < 65535) ? mh_a + 1 : mh_a;
         else   mm_a = (mm_a < 65535) ? mm_a + 1 : mm_a;
         n_cmp++;
         if (int'(hc_a) != mh_a || int'(mc_a) != mm_a) begin
            n_fail++;
            $display("FAIL %s perf a: got %0d/%0d exp %0d/%0d", name, hc_a, mc_a, mh_a, mm_a);
         end
      end else begin
         if (h) mh_b = (mh_b < 3) ? mh_b + 1 : mh_b;
         else   mm_b = (mm_b < 3) ? mm_b + 1 : mm_b;
         n_cmp++;
         if (int'(hc_b) != mh_b || int'(mc_b) != mm_b) begin
            n_fail++;
            $display("FAIL %s perf b: got %0d/%0d exp %0d/%0d", name, hc_b, mc_b, mh_b, mm_b);
         end
      end
`endif
   endtask

   task automatic test_reset;
      reset = 1'b1; rw = 1'b0; hit = 1'b0; dirty = 1'b0; strobe_a = 1'b1; strobe_b = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      idle_check(2, "reset_state");
      reset = 1'b0;
      mh_a = 0; mm_a = 0; mh_b = 0; mm_b = 0;
      idle_check(2, "post_reset_idle");
   endtask

   task automatic test_hit;
      run_txn(0, 1'b0, 1'b1, 1'b0, 1'b0, 1, "read_hit");
      run_txn(0, 1'b1, 1'b1, 1'b1, 1'b0, 1, "write_hit");
   endtask

   task automatic test_clean_miss;
      run_txn(0, 1'b0, 1'b0, 1'b0, 1'b0, 22, "clean_read_miss");
   endtask

   task automatic test_dirty_miss;
      run_txn(0, 1'b1, 1'b0, 1'b1, 1'b0, 42, "dirty_write_miss");
   endtask

   task automatic test_reset_mid;
      logic [17:0] ex;
      rw = 1'b0; dirty = 1'b0;
      for (int k = 0; k <= 14; k++) begin
         hit = 1'b0;
         strobe_a = (k == 0);
         if (k == 14) reset = 1'b1;
         @(negedge clk);
         ex = model(k, 4, 4, 1'b0, 1'b0, 1'b0);
         n_cmp++;
         if (obs_a !== ex) begin
            n_fail++;
            $display("FAIL reset_mid cyc %0d: got %h exp %h", k, obs_a, ex);
         end
         @(posedge clk); #1;
      end
      idle_check(1, "reset_mid_abort");
      reset = 1'b0;
      mh_a = 0; mm_a = 0; mh_b = 0; mm_b = 0;
      idle_check(1, "reset_mid_idle");
      run_txn(0, 1'b0, 1'b0, 1'b0, 1'b0, 22, "after_reset_miss");
   endtask

   task automatic test_small;
      run_txn(1, 1'b0, 1'b0, 1'b0, 1'b0, 4, "small_clean_miss");
      run_txn(1, 1'b1, 1'b0, 1'b1, 1'b0, 6, "small_dirty_miss");
      run_txn(1, 1'b1, 1'b1, 1'b0, 1'b0, 1, "small_write_hit");
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 40; i++) begin
         run_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b1, -1, "random_b2b");
         if ($urandom_range(0, 2) == 0) idle_check(1, "random_gap");
      end
   endtask

   task automatic test_perf;
`ifdef CACHE_CTRL_PERF_CNT_EN
      for (int i = 0; i < 4; i++) begin
         run_txn(1, 1'b0, 1'b1, 1'b0, 1'b0, 1, "perf_sat_hit");
         run_txn(1, 1'b0, 1'b0, 1'b0, 1'b0, 4, "perf_sat_miss");
      end
      n_cmp++;
      if (hc_b !== 2'd3 || mc_b !== 2'd3) begin
         n_fail++;
         $display("FAIL perf_saturate: got %0d/%0d exp 3/3", hc_b, mc_b);
      end
`endif
   endtask

   initial begin
      test_reset;
      test_hit;
      test_clean_miss;
      test_dirty_miss;
      test_reset_mid;
      test_small;
      test_back_to_back;
      test_perf;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
